// File: rtl/gf_pkg.sv
// gf_pkg: GF(2^8) constants, FSM encodings and affine/step helpers for the S-box engine
package gf_pkg;
  localparam logic [8:0] GF_POLY      = 9'h11B;
  localparam logic [7:0] GF_RED       = 8'h1B;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  localparam logic [7:0] FWD_AFFINE_C = 8'h63;
  localparam logic [7:0] EXPONENT     = 8'hFE;
  localparam int         N_OPS        = 15;
  localparam int         MUL_CYCLES   = 8;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_AFFINE = 2'd1;
  localparam logic [1:0] S_EXP    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++)
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ INV_AFFINE_C[i];
    return y;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] r);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++)
      y[i] = r[i] ^ r[(i + 4) % 8] ^ r[(i + 5) % 8] ^ r[(i + 6) % 8] ^ r[(i + 7) % 8] ^ FWD_AFFINE_C[i];
    return y;
  endfunction

  // One MSB-first multiply step: double-and-reduce, then conditionally add the multiplicand.
  function automatic logic [7:0] gf_step(input logic [7:0] p, input logic [7:0] a,
                                         input logic bit_k, input logic [7:0] red);
    return {p[6:0], 1'b0} ^ (p[7] ? red : 8'h00) ^ (bit_k ? a : 8'h00);
  endfunction
endpackage

// File: rtl/gf_mul_serial.sv
// gf_mul_serial: 8-cycle shift-and-reduce GF(2^8) multiplier; operands latched on start,
// done pulses for one cycle once p holds the final product.
module gf_mul_serial
  import gf_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] RED   = GF_RED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      a_d   = a;
      b_d   = {b[WIDTH-2:0], 1'b0};
      p_d   = gf_step('0, a, b[WIDTH-1], RED);
      cnt_d = 4'(MUL_CYCLES - 1);
    end else if (cnt_q != 4'd0) begin
      b_d    = {b_q[WIDTH-2:0], 1'b0};
      p_d    = gf_step(p_q, a_q, b_q[WIDTH-1], RED);
      cnt_d  = cnt_q - 4'd1;
      done_d = cnt_q == 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = p_q;
endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: iterative AES InvSubBytes (inverse affine then a^254 by square-and-multiply).
// Define SBOX_FWD_EN to add a mode port selecting forward SubBytes.
module inv_sub_bytes_seq
  import gf_pkg::*;
#(
  parameter int             WIDTH = 8,
  parameter logic [WIDTH:0] POLY  = GF_POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_byte,
`ifdef SBOX_FWD_EN
  input  logic             mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_byte,
  output logic             busy
);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, a_q, a_d, r_q, r_d;
  logic [3:0]       op_idx_q, op_idx_d;
  logic             mul_start, mul_done, mul_next;
  logic [WIDTH-1:0] mul_x, mul_y, mul_p;
  logic             fwd;
`ifdef SBOX_FWD_EN
  logic mode_q, mode_d;
  assign fwd = mode_q;
`else
  assign fwd = 1'b0;
`endif

  // After a SQ, the next op is a MUL whenever the exponent bit for this pair is set.
  assign mul_next = ~op_idx_q[0] & EXPONENT[3'd7 - op_idx_q[3:1]];

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    a_d       = a_q;
    r_d       = r_q;
    op_idx_d  = op_idx_q;
    mul_start = 1'b0;
    mul_x     = mul_p;
    mul_y     = mul_p;
`ifdef SBOX_FWD_EN
    mode_d    = mode_q;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        x_d     = in_byte;
        state_d = S_AFFINE;
`ifdef SBOX_FWD_EN
        mode_d  = mode;
`endif
      end
      S_AFFINE: begin
        a_d       = fwd ? x_q : inv_affine(x_q);
        r_d       = 8'h01;
        op_idx_d  = 4'd0;
        // First op squares r=1; issue it now so ops run back-to-back from here.
        mul_start = 1'b1;
        mul_x     = 8'h01;
        mul_y     = 8'h01;
        state_d   = S_EXP;
      end
      S_EXP: if (mul_done) begin
        r_d = mul_p;
        if (op_idx_q == 4'(N_OPS - 1)) state_d = S_DONE;
        else begin
          op_idx_d  = op_idx_q + 4'd1;
          mul_start = 1'b1;
          mul_y     = mul_next ? a_q : mul_p;
        end
      end
      default: state_d = out_ready ? S_IDLE : S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      a_q      <= '0;
      r_q      <= '0;
      op_idx_q <= '0;
`ifdef SBOX_FWD_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      a_q      <= a_d;
      r_q      <= r_d;
      op_idx_q <= op_idx_d;
`ifdef SBOX_FWD_EN
      mode_q   <= mode_d;
`endif
    end
  end

  gf_mul_serial #(.WIDTH(WIDTH), .RED(POLY[WIDTH-1:0])) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mul_start),
    .a    (mul_x),
    .b    (mul_y),
    .done (mul_done),
    .p    (mul_p)
  );

  assign in_ready  = state_q == S_IDLE;
  assign busy      = state_q != S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign out_byte  = out_valid ? (fwd ? fwd_affine(r_q) : r_q) : '0;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: scoreboard bench for inv_sub_bytes_seq against an S-box table
// built by brute-force field inversion.
module tb_inv_sub_bytes_seq;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_byte = 8'h00;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_byte;
`ifdef SBOX_FWD_EN
  logic mode = 1'b0;
`endif
  int         n_checks = 0, n_fail = 0;
  logic [7:0] sb_q[$];
  logic [7:0] sbox[256], isbox[256];

  always #5 clk = ~clk;

  inv_sub_bytes_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
`ifdef SBOX_FWD_EN
    .mode     (mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic run_byte(input logic [7:0] b, input logic [7:0] exp, input int hold, input bit poke);
    int n;
    logic [7:0] held;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_send", in_ready, 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_byte   = b;
    @(posedge clk); #1;
    sb_q.push_back(exp);
    in_valid = 1'b0;
    in_byte  = 8'h00;
    n = 0;
    while (!out_valid && n < 200) begin
      if (poke && n == 20) begin in_valid = 1'b1; in_byte = 8'hAA; end
      if (poke && n == 24) begin in_valid = 1'b0; in_byte = 8'h00; end
      @(posedge clk); #1; n++;
      if (poke && n > 20 && n <= 24) begin
        check("busy_in_ready", in_ready, 0);
        check("busy_flag", busy, 1);
      end
    end
    check("latency", n, 121);
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() != 0) check("out_byte", out_byte, sb_q.pop_front());
    held = out_byte;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bp_stable", out_byte, held);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", in_ready, 1);
    check("post_hs_byte", out_byte, 0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    build_tables();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_byte(8'h63, 8'h00, 0, 0);
    run_byte(8'h7C, 8'h01, 0, 0);
    run_byte(8'hED, 8'h53, 0, 0);
    run_byte(8'h00, 8'h52, 0, 0);
    run_byte(8'hFF, 8'h7D, 0, 0);
    run_byte(8'h52, 8'h48, 50, 0);
    run_byte(8'h63, 8'h00, 0, 1);

    in_valid = 1'b1;
    in_byte  = 8'h7C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back(8'h01);
    repeat (59) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_byte", out_byte, 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_byte(8'h7C, 8'h01, 0, 0);

    for (int i = 0; i < 256; i++) run_byte(8'(i), isbox[i], 0, 0);

`ifdef SBOX_FWD_EN
    mode = 1'b1;
    run_byte(8'h53, 8'hED, 0, 0);
    run_byte(8'h00, 8'h63, 0, 0);
    run_byte(8'h10, sbox[16], 0, 0);
    mode = 1'b0;
    run_byte(8'hED, 8'h53, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
